// File: rtl/sensor_pad_event_tracker.sv
// Sensor pad event tracker: groups an active-low sensor bus into pads, then
// synchronises, debounces and timestamps each pad. Press events go into a
// show-ahead FIFO that the consumer drains with valid/ready.

// Per-pad debouncer: tracks the debounced state, fires a one-cycle press
// pulse and captures the timestamp at the edge where the pad becomes pressed.
module sensor_pad_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TS_WIDTH        = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                raw_i,
  input  logic                enable_i,
  input  logic [TS_WIDTH-1:0] ts_i,
  output logic                active_o,
  output logic                pulse_o,
  output logic [TS_WIDTH-1:0] ts_hold_o
);
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DCW-1:0]      cnt_q, cnt_d;
  logic                active_q, active_d;
  logic                pulse_q, pulse_d;
  logic [TS_WIDTH-1:0] hold_q, hold_d;

  // Count consecutive disagreeing cycles; flip on the DEBOUNCE_CYCLES-th one
  always_comb begin
    cnt_d    = '0;
    active_d = active_q;
    pulse_d  = 1'b0;
    hold_d   = hold_q;
    if (raw_i != active_q) begin
      if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
        active_d = raw_i;
        if (raw_i && enable_i) begin
          pulse_d = 1'b1;
          hold_d  = ts_i;
        end
      end else begin
        cnt_d = cnt_q + DCW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      hold_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
      hold_q   <= hold_d;
    end
  end

  assign active_o  = active_q;
  assign pulse_o   = pulse_q;
  assign ts_hold_o = hold_q;
endmodule

module sensor_pad_event_tracker #(
  parameter int  NUM_PADS        = 3,
  parameter int  SENSORS_PER_PAD = 5,
  parameter int  DEBOUNCE_CYCLES = 16,
  parameter int  FIFO_DEPTH      = 8,
  parameter int  TS_WIDTH        = 16,
  localparam int PW              = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
  localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [NUM_PADS*SENSORS_PER_PAD-1:0] sensor_in,
  input  logic                                enable,
  input  logic                                clear_overflow,
  input  logic                                evt_ready,
  output logic [NUM_PADS-1:0]                 pad_active,
  output logic [NUM_PADS-1:0]                 press_pulse,
  output logic                                evt_valid,
  output logic [PW-1:0]                       evt_pad,
  output logic [TS_WIDTH-1:0]                 evt_time,
  output logic [CW-1:0]                       evt_count,
  output logic                                overflow
);
  localparam int SW = NUM_PADS * SENSORS_PER_PAD;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [PW-1:0]       pad;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  logic [SW-1:0]       sync1_q, sync2_q;
  logic [TS_WIDTH-1:0] ts_q;

  // Two-flop synchroniser, idle (all-ones) out of reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sensor_in;
      sync2_q <= sync1_q;
    end
  end

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clock) begin
    if (!resetn) ts_q <= '0;
    else         ts_q <= ts_q + TS_WIDTH'(1);
  end

  logic [NUM_PADS-1:0]                raw;
  logic [NUM_PADS-1:0][TS_WIDTH-1:0]  ts_hold;

  generate
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      // Any touched (low) sensor in the group presses the pad
      assign raw[p] = |(~sync2_q[p*SENSORS_PER_PAD +: SENSORS_PER_PAD]);

      sensor_pad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TS_WIDTH        (TS_WIDTH)
      ) u_db (
        .clock     (clock),
        .resetn    (resetn),
        .raw_i     (raw[p]),
        .enable_i  (enable),
        .ts_i      (ts_q),
        .active_o  (pad_active[p]),
        .pulse_o   (press_pulse[p]),
        .ts_hold_o (ts_hold[p])
      );
    end
  endgenerate

  // Arbiter: a fresh pulse is serviceable in its own cycle, so an uncontended
  // press reaches the FIFO on the edge right after the pulse.
  logic [NUM_PADS-1:0] pending_q, pending_d, cand, grant;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_any;

  assign cand      = pending_q | press_pulse;
  assign grant     = cand & (~cand + NUM_PADS'(1));
  assign gnt_any   = |cand;
  assign pending_d = cand & ~grant;

  // Lowest-index candidate wins
  always_comb begin
    gnt_idx = '0;
    for (int p = NUM_PADS - 1; p >= 0; p--) begin
      if (cand[p]) gnt_idx = PW'(p);
    end
  end

  // Pending register
  always_ff @(posedge clock) begin
    if (!resetn) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // Event FIFO
  evt_t          mem_q [FIFO_DEPTH];
  evt_t          push_evt;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop, push, full, drop;

  assign push_evt = '{pad: gnt_idx, ts: ts_hold[gnt_idx]};
  assign pop      = (cnt_q != '0) && evt_ready;
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign push     = gnt_any && (!full || pop);
  assign drop     = gnt_any && !push;

  // Occupancy and sticky overflow next-state; a drop beats a clear
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  // FIFO pointers, count and overflow
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset; the count qualifies every entry
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= push_evt;
  end

  assign evt_valid = (cnt_q != '0);
  assign evt_pad   = mem_q[rd_q].pad;
  assign evt_time  = mem_q[rd_q].ts;
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_sensor_pad_event_tracker.sv
// Directed bench for sensor_pad_event_tracker with a scoreboard queue of
// expected events, popped by a monitor whenever the consumer takes one.
module tb_sensor_pad_event_tracker;
  localparam int NP  = 3;
  localparam int SPP = 5;
  localparam int DB  = 4;
  localparam int FD  = 8;
  localparam int TW  = 8;
  localparam int PW  = 2;
  localparam int CW  = 4;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [NP*SPP-1:0] sensor_in = '1;
  logic              enable = 1'b1;
  logic              clear_overflow = 1'b0;
  logic              evt_ready = 1'b0;
  logic [NP-1:0]     pad_active, press_pulse;
  logic              evt_valid;
  logic [PW-1:0]     evt_pad;
  logic [TW-1:0]     evt_time;
  logic [CW-1:0]     evt_count;
  logic              overflow;

  sensor_pad_event_tracker #(
    .NUM_PADS        (NP),
    .SENSORS_PER_PAD (SPP),
    .DEBOUNCE_CYCLES (DB),
    .FIFO_DEPTH      (FD),
    .TS_WIDTH        (TW)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .sensor_in      (sensor_in),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .evt_ready      (evt_ready),
    .pad_active     (pad_active),
    .press_pulse    (press_pulse),
    .evt_valid      (evt_valid),
    .evt_pad        (evt_pad),
    .evt_time       (evt_time),
    .evt_count      (evt_count),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  typedef struct { int pad; int ts; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pulse_cnt[NP];
  logic [TW-1:0] tb_ts = '0;

  // Reference timestamp: cleared by reset, +1 per edge
  always @(posedge clock) tb_ts <= resetn ? tb_ts + TW'(1) : '0;

  // Monitor: a pop happens on the coming edge whenever valid && ready
  always @(negedge clock) begin
    if (resetn) begin
      if (evt_valid && evt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL evt_unexpected pad=%0d time=%0d", evt_pad, evt_time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (evt_pad !== PW'(e.pad) || evt_time !== TW'(e.ts)) begin
            errors++;
            $display("FAIL evt_head actual pad=%0d time=%0d expected pad=%0d time=%0d",
                     evt_pad, evt_time, e.pad, e.ts);
          end
        end
      end
      for (int p = 0; p < NP; p++) if (press_pulse[p]) pulse_cnt[p]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Touch one sensor; the pad rises DB+1 edges later, capturing tb_ts+DB+1
  task automatic press(input int bit_idx, input int pad, input bit keep);
    logic [TW-1:0] t;
    t = tb_ts + TW'(DB + 1);
    sensor_in[bit_idx] = 1'b0;
    if (keep) exp_q.push_back('{pad: pad, ts: int'(t)});
  endtask

  task automatic press_release(input int bit_idx, input int pad, input bit keep);
    press(bit_idx, pad, keep);
    tick(DB + 3);
    sensor_in[bit_idx] = 1'b1;
    tick(DB + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int p = 0; p < NP; p++) pulse_cnt[p] = 0;

    // Reset state
    tick(2);
    chk("rst_pad_active", pad_active, 0);
    chk("rst_press_pulse", press_pulse, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_count", evt_count, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;

    // Debounce latency: timestamp starts at 0, pad 1 rises at edge 5
    sensor_in[7] = 1'b0;
    exp_q.push_back('{pad: 1, ts: 5});
    tick(5);
    chk("db_edge4_active", pad_active, 0);
    tick(1);
    chk("db_edge5_active", pad_active, 3'b010);
    chk("db_edge5_pulse", press_pulse, 3'b010);
    tick(1);
    chk("db_pulse_once", press_pulse, 0);
    chk("db_evt_count", evt_count, 1);
    chk("db_evt_valid", evt_valid, 1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("db_drained", evt_count, 0);
    sensor_in[7] = 1'b1;
    tick(DB + 3);
    chk("db_released", pad_active, 0);
    chk("db_pulse_count", pulse_cnt[1], 1);

    // Three-cycle glitch must be filtered
    sensor_in[2] = 1'b0;
    tick(3);
    sensor_in[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_active", pad_active[0], 0);
    end
    chk("glitch_pulses", pulse_cnt[0], 0);
    chk("glitch_count", evt_count, 0);

    // Simultaneous pads 0 and 2: pad 0 first, same timestamp, consecutive pushes
    press(0, 0, 1'b1);
    press(14, 2, 1'b1);
    tick(DB + 2);
    chk("sim_pulse", press_pulse, 3'b101);
    tick(1);
    chk("sim_count1", evt_count, 1);
    tick(1);
    chk("sim_count2", evt_count, 2);
    evt_ready = 1'b1;
    tick(2);
    evt_ready = 1'b0;
    chk("sim_drained", evt_count, 0);
    sensor_in[0] = 1'b1;
    sensor_in[14] = 1'b1;
    tick(DB + 3);

    // Overflow: eight kept, ninth dropped
    for (int i = 0; i < FD; i++) press_release(0, 0, 1'b1);
    chk("ovf_full_count", evt_count, FD);
    chk("ovf_not_yet", overflow, 0);
    press_release(0, 0, 1'b0);
    chk("ovf_count", evt_count, FD);
    chk("ovf_set", overflow, 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Clear in the same cycle as a drop: the drop wins
    press(1, 0, 1'b0);
    tick(DB + 2);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_count2", evt_count, FD);
    sensor_in[1] = 1'b1;
    tick(DB + 3);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared2", overflow, 0);

    // Full FIFO with a same-cycle pop accepts the new event at the tail
    press(14, 2, 1'b1);
    tick(DB + 2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("fullpop_count", evt_count, FD);
    chk("fullpop_no_ovf", overflow, 0);
    sensor_in[14] = 1'b1;
    tick(DB + 3);
    evt_ready = 1'b1;
    tick(FD + 2);
    evt_ready = 1'b0;
    chk("fullpop_drained", evt_count, 0);
    chk("fullpop_sb_empty", exp_q.size(), 0);

    // Reset in the middle of filling
    press(3, 0, 1'b1);
    press(6, 1, 1'b1);
    tick(DB + 4);
    chk("midrst_before", evt_count, 2);
    sensor_in = '1;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    exp_q.delete();
    chk("midrst_count", evt_count, 0);
    chk("midrst_valid", evt_valid, 0);
    chk("midrst_active", pad_active, 0);

    // enable = 0: pad state follows, no pulse, no event
    enable = 1'b0;
    base = pulse_cnt[1];
    sensor_in[7] = 1'b0;
    tick(DB + 2);
    chk("en0_active", pad_active, 3'b010);
    chk("en0_pulse", press_pulse, 0);
    tick(3);
    chk("en0_count", evt_count, 0);
    chk("en0_pulse_count", pulse_cnt[1] - base, 0);
    sensor_in[7] = 1'b1;
    tick(DB + 3);
    enable = 1'b1;

    // Timestamp wrap: pad 0 captures 255, pad 1 one edge later captures 0
    for (int i = 0; i < 300 && tb_ts != TW'(250); i++) tick(1);
    chk("wrap_wait", tb_ts, 250);
    sensor_in[0] = 1'b0;
    exp_q.push_back('{pad: 0, ts: 255});
    tick(1);
    sensor_in[5] = 1'b0;
    exp_q.push_back('{pad: 1, ts: 0});
    tick(DB + 4);
    chk("wrap_count", evt_count, 2);
    evt_ready = 1'b1;
    tick(3);
    evt_ready = 1'b0;
    chk("wrap_drained", evt_count, 0);
    sensor_in = '1;
    tick(DB + 3);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
